r2r_sample_player: RTL and testbench
====================================

# r2r_sample_player

Buffered playback engine that converts the ADC sample stream back into analog by driving the 8-bit R2R ladder header at a fixed, programmable sample rate. Samples arrive on a valid/ready push interface fed by `adc_processing` (`scaled_adc_data` qualified by `ready_pulse`) and enter a small FIFO. A pacing counter pops one sample per sample period onto `R2R_out`. Sits beside `triangle_generator` in the top level; the output-mode FSM selects between the two sources through its enable.

## Interface
- `DATA_WIDTH`, 16: width of incoming samples.
- `DAC_WIDTH`, 8: R2R ladder width; the top `DAC_WIDTH` bits of each sample are stored.
- `DEPTH`, 16: FIFO entries; must be a power of 2, ≥4.
- `CLOCK_FREQ`, 100_000_000: system clock in Hz.
- `SAMPLE_RATE`, 10_000: playback rate in Hz. `DIV = CLOCK_FREQ/SAMPLE_RATE` (integer division), must be ≥2.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  playback enable from the mode FSM.
- `in_valid`  in  1  sample present on `in_data`.
- `in_data`  in  DATA_WIDTH  sample (unsigned).
- `in_ready`  out  1  FIFO can accept a sample this cycle.
- `R2R_out`  out  DAC_WIDTH  ladder drive, registered.
- `sample_strobe`  out  1  one-cycle pulse in the first cycle a new `R2R_out` value is visible.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `playing`  out  1  high while in PLAY.
- `underflow`  out  1  sticky: a tick found the FIFO empty.
- `overflow`  out  1  sticky: a sample was offered while the FIFO was full.

## Operation
- States: IDLE, PRIME, PLAY.
- IDLE: FIFO flushed (`fifo_count` = 0), `R2R_out` = 0, pacing counter = 0, `in_ready` = 0, and `in_valid` is ignored with no flag set. Go to PRIME when `enable` = 1.
- On the IDLE→PRIME transition, `underflow` and `overflow` are cleared.
- PRIME: pushes are accepted. Go to PLAY when `fifo_count` ≥ DEPTH/2. `R2R_out` holds its value.
- PLAY: the pacing counter counts 0..DIV-1 and wraps. A tick occurs when the counter = DIV-1.
  - Tick with `fifo_count` > 0: pop the oldest entry into `R2R_out`.
  - Tick with `fifo_count` = 0: hold `R2R_out`, set `underflow`, return to PRIME.
- `enable` = 0 in any state: go to IDLE next cycle; this takes priority over every other transition.
- Push rule: `in_ready` = (state ≠ IDLE) && (`fifo_count` < DEPTH), combinational from registered state/count. A push occurs when `in_valid` && `in_ready`.
- `in_valid` && `fifo_count` = DEPTH outside IDLE: sample dropped, `overflow` set. This holds even if a pop happens in the same cycle.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- Stored word = `in_data[DATA_WIDTH-1 -: DAC_WIDTH]` (truncation, no rounding). Pointers wrap modulo DEPTH.
- FIFO ordering is strictly first-in, first-out. No sample is duplicated or skipped except as a drop under the overflow rule.

## Timing
- Reset values: `R2R_out` = 0, `sample_strobe` = 0, `fifo_count` = 0, `playing` = 0, `underflow` = 0, `overflow` = 0, `in_ready` = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation: all of the above are applied immediately; FIFO contents are discarded.
- `enable` rising at edge N: PRIME from edge N; `in_ready` high in cycle N+1 (FIFO not full).
- Pushes are counted at the edge where `in_valid` && `in_ready`; `fifo_count` reflects the push one cycle later.
- Entering PLAY resets the counter to 0. The first tick is at the DIV-th PLAY cycle, and subsequent ticks follow every DIV cycles.
- Pop latency: `R2R_out` updates at the tick edge. `sample_strobe` is registered and high for exactly the following cycle. No strobe is issued on an underflow tick.
- `playing` is registered, equal to (state == PLAY).

## Test plan
- Parameters for all scenarios: CLOCK_FREQ=1000, SAMPLE_RATE=100 (DIV=10), DEPTH=4.
- Reset mid-PLAY with 3 entries: assert `reset` asynchronously → all outputs return to reset values within the same cycle, and the FIFO is empty after release.
- Priming and pacing: `enable`=1, push 0x1100, 0x2200 → PLAY after the second push. `R2R_out` = 0x11, then 0x22, exactly 10 cycles apart, each accompanied by a single-cycle `sample_strobe`.
- Underflow: prime with 2 samples and push nothing more → the third tick leaves `R2R_out` = 0x22, `underflow`=1, `playing`=0, state PRIME. A further 2 pushes resume PLAY.
- Overflow: in PRIME/PLAY, push 5 samples back-to-back with no tick → `in_ready` low after the fourth, the fifth is dropped, `overflow`=1, `fifo_count`=4. Playback then emits only the first four samples, in order.
- Full with simultaneous pop: `fifo_count`=4, `in_valid`=1 on the tick cycle → the pop happens, the push is refused, `overflow`=1, `fifo_count`=3.
- Disable/re-enable: drop `enable` in PLAY → next cycle IDLE, `R2R_out`=0, `fifo_count`=0, pushes ignored. Re-raise `enable` → sticky flags cleared.

Source files
------------

// File: rtl/r2r_sample_player_if.sv
`default_nettype none
// ============================================================================
// Module   : r2r_sample_player_if
// Purpose  : Valid/ready sample push bus into the R2R sample player.
// Revision : 1.0
// ============================================================================
interface r2r_sample_player_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/r2r_sample_player.sv
`default_nettype none
// ============================================================================
// Module   : r2r_sample_player
// Purpose  : Buffered, rate-paced playback of samples onto an R2R ladder.
// Revision : 1.0
// ============================================================================
module r2r_sample_player #(
  parameter int DATA_WIDTH  = 16,
  parameter int DAC_WIDTH   = 8,
  parameter int DEPTH       = 16,
  parameter int CLOCK_FREQ  = 100_000_000,
  parameter int SAMPLE_RATE = 10_000
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   enable,
  r2r_sample_player_if.slave          bus,
  output logic [DAC_WIDTH-1:0]        R2R_out,
  output logic                        sample_strobe,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        playing,
  output logic                        underflow,
  output logic                        overflow
);

  localparam int DIV   = CLOCK_FREQ / SAMPLE_RATE;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0]    C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]    C_HALF  = CW'(DEPTH / 2);
  localparam logic [DIV_W-1:0] C_TICK  = DIV_W'(DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [DAC_WIDTH-1:0] r_mem [DEPTH];

  logic                 w_full;
  logic                 w_empty;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_tick;
  logic                 w_pop;
  logic                 w_starve;
  logic [DAC_WIDTH-1:0] w_word;
  logic                 w_data_unused;

  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  assign w_ready  = (r_state != ST_IDLE) && !w_full;
  assign w_push   = bus.in_valid && w_ready;
  assign w_tick   = (r_state == ST_PLAY) && (r_div_cnt == C_TICK);
  assign w_pop    = enable && w_tick && !w_empty;
  assign w_starve = enable && w_tick && w_empty;
  assign w_word   = bus.in_data[DATA_WIDTH-1 -: DAC_WIDTH];

  // Low-order sample bits are discarded by truncation.
  assign w_data_unused = ^bus.in_data;

  assign bus.in_ready = w_ready;
  assign fifo_count   = r_count;

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_PRIME;
        ST_PRIME: if (r_count >= C_HALF) w_state_nxt = ST_PLAY;
        ST_PLAY:  if (w_starve) w_state_nxt = ST_PRIME;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      playing       <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_div_cnt     <= '0;
      R2R_out       <= '0;
      sample_strobe <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      playing <= (w_state_nxt == ST_PLAY);
      if (!enable) begin
        // Dropping enable flushes the FIFO and parks the ladder at zero.
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_count       <= '0;
        r_div_cnt     <= '0;
        R2R_out       <= '0;
        sample_strobe <= 1'b0;
      end else begin
        sample_strobe <= w_pop;
        if (w_pop) begin
          R2R_out  <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if ((r_state == ST_PLAY) && (w_state_nxt == ST_PLAY)) begin
          r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        end else begin
          r_div_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if ((r_state == ST_IDLE) && enable) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // A full FIFO refuses the offer even if a pop frees a slot this cycle.
      if (bus.in_valid && w_full && (r_state != ST_IDLE)) overflow <= 1'b1;
      if (w_starve) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_r2r_sample_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_r2r_sample_player
// Purpose  : Directed + random checks of r2r_sample_player against a queue model.
// Revision : 1.0
// ============================================================================
module tb_r2r_sample_player;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [AW-1:0]     R2R_out;
  logic              sample_strobe;
  logic [2:0]        fifo_count;
  logic              playing;
  logic              underflow;
  logic              overflow;

  always #5 clk = ~clk;

  r2r_sample_player_if #(.DATA_WIDTH(DW)) bus ();

  r2r_sample_player #(
    .DATA_WIDTH (DW),
    .DAC_WIDTH  (AW),
    .DEPTH      (DEPTH),
    .CLOCK_FREQ (1000),
    .SAMPLE_RATE(100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (bus),
    .R2R_out      (R2R_out),
    .sample_strobe(sample_strobe),
    .fifo_count   (fifo_count),
    .playing      (playing),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue plus "play clock" that counts cycles spent playing.
  logic [AW-1:0] q[$];
  bit            m_active, m_play, m_strobe, m_under, m_over;
  int            m_phase;
  logic [AW-1:0] m_r2r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; m_play = 0; m_strobe = 0; m_under = 0; m_over = 0;
    m_phase  = 0; m_r2r = '0;
  endtask

  task automatic model_update(input bit e, input bit v, input logic [DW-1:0] d);
    int n0;
    bit rdy;
    n0  = q.size();
    rdy = m_active && (n0 < DEPTH);
    if (v && m_active && n0 == DEPTH) m_over = 1;
    if (!e) begin
      q.delete();
      m_active = 0; m_play = 0; m_phase = 0; m_r2r = '0; m_strobe = 0;
    end else if (!m_active) begin
      m_active = 1; m_under = 0; m_over = 0; m_strobe = 0;
    end else begin
      m_strobe = 0;
      if (m_play) begin
        if (m_phase == DIV - 1) begin
          m_phase = 0;
          if (n0 > 0) begin
            m_r2r    = q.pop_front();
            m_strobe = 1;
          end else begin
            m_under = 1;
            m_play  = 0;
          end
        end else begin
          m_phase++;
        end
      end else if (n0 >= DEPTH / 2) begin
        m_play  = 1;
        m_phase = 0;
      end
      if (v && rdy) q.push_back(d[DW-1 -: AW]);
    end
  endtask

  task automatic check_all();
    chk("r2r_out",   R2R_out,       m_r2r);
    chk("strobe",    sample_strobe, m_strobe);
    chk("count",     fifo_count,    q.size());
    chk("playing",   playing,       m_play);
    chk("underflow", underflow,     m_under);
    chk("overflow",  overflow,      m_over);
    chk("in_ready",  bus.in_ready,  m_active && (q.size() < DEPTH));
  endtask

  task automatic step(input bit e, input bit v, input logic [DW-1:0] d);
    enable       = e;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    model_update(e, v, d);
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_r2r"},      R2R_out,       '0);
    chk({tag, "_strobe"},   sample_strobe, 0);
    chk({tag, "_count"},    fifo_count,    0);
    chk({tag, "_playing"},  playing,       0);
    chk({tag, "_under"},    underflow,     0);
    chk({tag, "_over"},     overflow,      0);
    chk({tag, "_in_ready"}, bus.in_ready,  0);
  endtask

  int            scyc[$];
  logic [AW-1:0] sval[$];
  bit            hit;

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    // Priming and pacing, then underflow on the third tick.
    step(1, 0, 16'h0000);
    step(1, 1, 16'h1100);
    step(1, 1, 16'h2200);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 16'h0000);
      if (sample_strobe) begin
        scyc.push_back(i);
        sval.push_back(R2R_out);
      end
    end
    chk("pace_strobes", scyc.size(), 2);
    if (scyc.size() >= 2) begin
      chk("pace_first",  sval[0], 8'h11);
      chk("pace_second", sval[1], 8'h22);
      chk("pace_gap",    scyc[1] - scyc[0], DIV);
    end
    chk("uf_r2r",     R2R_out,   8'h22);
    chk("uf_flag",    underflow, 1);
    chk("uf_playing", playing,   0);
    step(1, 1, 16'h3300);
    step(1, 1, 16'h4400);
    step(1, 0, 16'h0000);
    chk("uf_resume", playing, 1);

    // Disable in PLAY, pushes ignored, re-enable clears sticky flags.
    step(0, 0, 16'h0000);
    chk("dis_r2r",   R2R_out,      '0);
    chk("dis_count", fifo_count,   0);
    chk("dis_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'(($urandom)));
    chk("dis_ignored", fifo_count, 0);
    step(1, 0, 16'h0000);
    chk("reen_under", underflow, 0);
    chk("reen_over",  overflow,  0);

    // Overflow: five back-to-back offers, then an offer on a full tick.
    step(1, 1, 16'hA100);
    step(1, 1, 16'hB200);
    step(1, 1, 16'hC300);
    step(1, 1, 16'hD400);
    chk("ovf_ready_low", bus.in_ready, 0);
    step(1, 1, 16'hE500);
    chk("ovf_flag",  overflow,   1);
    chk("ovf_count", fifo_count, 4);
    hit = 0;
    for (int i = 0; i < 2 * DIV && !hit; i++) begin
      hit = m_play && (m_phase == DIV - 1);
      step(1, hit, 16'hFF00);
    end
    chk("full_tick_seen", hit,        1);
    chk("full_pop_r2r",   R2R_out,    8'hA1);
    chk("full_pop_count", fifo_count, 3);
    chk("full_pop_over",  overflow,   1);
    sval.delete();
    for (int i = 0; i < 4 * DIV; i++) begin
      step(1, 0, 16'h0000);
      if (sample_strobe) sval.push_back(R2R_out);
    end
    chk("drain_n", sval.size(), 3);
    if (sval.size() == 3) begin
      chk("drain_0", sval[0], 8'hB2);
      chk("drain_1", sval[1], 8'hC3);
      chk("drain_2", sval[2], 8'hD4);
    end
    step(0, 0, 16'h0000);

    // Asynchronous reset mid-PLAY with three entries.
    step(1, 0, 16'h0000);
    step(1, 1, 16'h1234);
    step(1, 1, 16'h5678);
    step(1, 1, 16'h9ABC);
    step(1, 0, 16'h0000);
    chk("pre_rst_playing", playing,    1);
    chk("pre_rst_count",   fifo_count, 3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("arst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0000);
    chk("post_rst_empty", fifo_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 25), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
